// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: command handshake, raw line levels and open-drain enables.
// The requester (master) drives the command and line levels; the transmitter (slave) drives status.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 10 device-clocked bits,
// ACK sample and bus-idle wait, guarded by a watchdog. All outputs are registered.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic          clk,
    input logic          rst,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FltW   = $clog2(FILTER_LEN + 1);
    localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] WdLast  = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [FltW-1:0] FltLast = FltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StBits,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      clk_sync_q, data_sync_q;
    logic            filt_q, filt_d;
    logic [FltW-1:0] flt_cnt_q, flt_cnt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      n_q, n_d;
    logic [8:0]      shift_q, shift_d;
    logic            ack_bad_q, ack_bad_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            timeout_q, timeout_d;
    logic            clk_s, data_s, fe, wd_hit;
    logic [3:0]      bit_idx;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d    = filt_q;
        flt_cnt_d = '0;
        if (clk_s != filt_q) begin
            if (flt_cnt_q == FltLast) begin
                filt_d = clk_s;
            end else begin
                flt_cnt_d = flt_cnt_q + FltW'(1);
            end
        end
    end

    assign fe     = filt_q & ~filt_d;
    assign wd_hit = (state_q inside {StReq, StBits, StAck, StWaitIdle}) && (cnt_q == WdLast);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        shift_d   = shift_q;
        ack_bad_d = ack_bad_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.tx_valid) begin
                    shift_d = {~^bus.tx_data, bus.tx_data};
                    cnt_d   = '0;
                    state_d = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == InhLast) begin
                    cnt_d   = '0;
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq: begin
                cnt_d   = cnt_q + CntW'(1);
                n_d     = '0;
                state_d = StBits;
            end
            StBits: begin
                cnt_d = cnt_q + CntW'(1);
                if (fe) begin
                    n_d = n_q + 4'd1;
                    if (n_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                cnt_d = cnt_q + CntW'(1);
                if (fe) begin
                    ack_bad_d = data_s;
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                cnt_d = cnt_q + CntW'(1);
                if (clk_s && data_s) begin
                    done_d    = ~ack_bad_q;
                    ack_err_d = ack_bad_q;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Watchdog overrides every other transition and suppresses done/ack_err.
        if (wd_hit) begin
            state_d   = StIdle;
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            timeout_d = 1'b1;
        end
    end

    // Outputs are derived from the next state so the registered value matches the state.
    always_comb begin
        bit_idx   = n_d - 4'd1;
        clk_oe_d  = (state_d == StInhibit);
        busy_d    = (state_d != StIdle);
        ready_d   = (state_d == StIdle);
        data_oe_d = 1'b0;
        unique case (state_d)
            StInhibit: data_oe_d = (cnt_d == InhLast);
            StReq:     data_oe_d = 1'b1;
            StBits: begin
                if (n_d == 4'd0) begin
                    data_oe_d = 1'b1;
                end else if (n_d <= 4'd9) begin
                    data_oe_d = ~shift_q[bit_idx];
                end
            end
            default:   data_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            flt_cnt_q   <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            shift_q     <= '0;
            ack_bad_q   <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            ack_err_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= {clk_sync_q[0], bus.ps2_clk_in};
            data_sync_q <= {data_sync_q[0], bus.ps2_data_in};
            filt_q      <= filt_d;
            flt_cnt_q   <= flt_cnt_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            shift_q     <= shift_d;
            ack_bad_q   <= ack_bad_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            ack_err_q   <= ack_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus.tx_ready    = ready_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.ack_err     = ack_err_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and the observed
// data enables are compared with bit patterns computed from the command byte.
module tb_ps2_host_tx;

    localparam int INH  = 120;
    localparam int FLT  = 8;
    localparam int TO   = 3000;
    localparam int HALF = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    int n_checks = 0;
    int n_errs = 0;
    int n_done = 0;
    int n_ack = 0;
    int n_to = 0;
    int n_bad_busy = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .FILTER_LEN    (FLT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Open-drain wired-AND of the device and the host pull-downs.
    assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

    always @(negedge clk) begin
        if (bus.done) n_done++;
        if (bus.ack_err) n_ack++;
        if (bus.timeout) n_to++;
        if ((bus.done || bus.ack_err || bus.timeout) && bus.busy) n_bad_busy++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected data_oe after falling edges 1..11: inverted data LSB first, inverted odd
    // parity, then released for the stop bit and the ACK bit.
    function automatic logic [10:0] exp_bits(input logic [7:0] d);
        logic [10:0] e;
        logic        p;
        p = (($countones(d) % 2) == 0);
        e = '0;
        for (int i = 0; i < 8; i++) e[i] = ~d[i];
        e[8] = ~p;
        return e;
    endfunction

    // Send one byte; returns the number of clk_oe-high cycles seen.
    task automatic start_send(input logic [7:0] d, input bit poke_busy, output int inh_cnt);
        int w;
        w = 0;
        while (!bus.tx_ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_send", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        inh_cnt = 0;
        while (bus.ps2_clk_oe && inh_cnt < 4 * INH) begin
            inh_cnt++;
            if (poke_busy && inh_cnt == 5) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'($urandom);
            end
            if (inh_cnt == 8) bus.tx_valid = 1'b0;
            @(negedge clk);
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] d, input bit give_ack, input bit glitch,
                            input int rst_edge);
        int          inh;
        int          d0, a0, t0;
        logic [10:0] obs;
        d0 = n_done;
        a0 = n_ack;
        t0 = n_to;
        obs = '0;
        start_send(d, 1'b1, inh);
        check("inhibit_len", 32'(inh), 32'(INH));
        check("start_bit", 32'(bus.ps2_data_oe), 32'd1);
        repeat (40) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = give_ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            obs[k-1] = bus.ps2_data_oe;
            if (k == rst_edge) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_release", {29'd0, bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy}, 32'd0);
                rst = 1'b0;
                dev_clk = 1'b1;
                repeat (50) @(negedge clk);
                check("rst_no_pulse", 32'((n_done - d0) + (n_ack - a0) + (n_to - t0)), 32'd0);
                check("rst_ready", 32'(bus.tx_ready), 32'd1);
                return;
            end
            dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
            if (glitch && k <= 9) begin
                repeat (16) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 19) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        repeat (20) @(negedge clk);
        check("frame_bits", 32'(obs), 32'(exp_bits(d)));
        check("done_cnt", 32'(n_done - d0), give_ack ? 32'd1 : 32'd0);
        check("ack_err_cnt", 32'(n_ack - a0), give_ack ? 32'd0 : 32'd1);
        check("no_timeout", 32'(n_to - t0), 32'd0);
        check("idle_not_queued", {30'd0, bus.busy, bus.tx_ready}, 32'd1);
    endtask

    task automatic timeout_frame(input logic [7:0] d);
        int inh, w, d0, a0;
        d0 = n_done;
        a0 = n_ack;
        start_send(d, 1'b0, inh);
        check("to_inhibit_len", 32'(inh), 32'(INH));
        w = 0;
        while (!bus.timeout && w < TO + 100) begin
            @(negedge clk);
            w++;
        end
        check("timeout_len", 32'(w), 32'(TO));
        check("timeout_lines", {29'd0, bus.ps2_clk_oe, bus.ps2_data_oe, bus.tx_ready}, 32'd1);
        repeat (5) @(negedge clk);
        check("timeout_exclusive", 32'((n_done - d0) + (n_ack - a0)), 32'd0);
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {25'd0, bus.tx_ready, bus.busy, bus.ps2_clk_oe, bus.ps2_data_oe,
                              bus.done, bus.ack_err, bus.timeout}, 32'h40);

        do_frame(8'hED, 1'b1, 1'b0, 0);
        do_frame(8'hFF, 1'b1, 1'b0, 0);
        do_frame(8'h00, 1'b1, 1'b0, 0);
        do_frame(8'($urandom), 1'b0, 1'b0, 0);
        do_frame(8'($urandom), 1'b1, 1'b1, 0);
        timeout_frame(8'($urandom));
        do_frame(8'($urandom), 1'b1, 1'b0, 5);
        do_frame(8'hF4, 1'b1, 1'b0, 0);
        for (int i = 0; i < 6; i++) begin
            do_frame(8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 0);
        end

        check("busy_low_at_pulse", 32'(n_bad_busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
